// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART message sequencer.
// Defaults target a 100 MHz clock at 9600 baud.
package uart_pkg;

    localparam int BIT_CYCLES_DEFAULT = 10416;
    localparam int FRAME_BITS_DEFAULT = 11;
    localparam int MSG_LEN_DEFAULT    = 6;

    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_X  = 8'h78;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/hex_to_ascii.sv
// Converts one nibble to its uppercase ASCII hex digit.
// Purely combinational.
module hex_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    logic [7:0] wide;

    assign wide = {4'h0, nibble};

    // Digits 0-9 map from '0', letters A-F map from 'A'.
    always_comb begin
        if (nibble <= 4'd9) begin
            ascii = 8'h30 + wide;
        end else begin
            ascii = 8'h41 + (wide - 8'd10);
        end
    end

endmodule

// File: rtl/uart_msg_ctrl.sv
// Emits "0x" + two hex digits + CR LF, one byte per UART frame.
// The send module has no ready, so frames are paced by a local counter.
module uart_msg_ctrl
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_DEFAULT,
    parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
    parameter int MSG_LEN    = MSG_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] value,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done
);

    localparam int FRAME_CYCLES = BIT_CYCLES * FRAME_BITS;
    localparam int CW = $clog2(FRAME_CYCLES + 1);
    localparam int IW = $clog2(MSG_LEN);

    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(MSG_LEN - 1);

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]    val_q;
    logic [7:0]    val_d;

    logic          tx_valid_d;
    logic [7:0]    tx_data_d;
    logic          busy_d;
    logic          done_d;

    logic [7:0]    hi_char;
    logic [7:0]    lo_char;
    logic [7:0]    msg_byte;

    hex_to_ascii u_hex_hi (
        .nibble (val_q[7:4]),
        .ascii  (hi_char)
    );

    hex_to_ascii u_hex_lo (
        .nibble (val_q[3:0]),
        .ascii  (lo_char)
    );

    // Select the byte for the current message position.
    always_comb begin
        unique case (idx_q)
            IW'(0):  msg_byte = CHAR_0;
            IW'(1):  msg_byte = CHAR_X;
            IW'(2):  msg_byte = hi_char;
            IW'(3):  msg_byte = lo_char;
            IW'(4):  msg_byte = CHAR_CR;
            IW'(5):  msg_byte = CHAR_LF;
            default: msg_byte = 8'h00;
        endcase
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        val_d      = val_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data;
        busy_d     = busy;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    val_d   = value;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid_d = 1'b1;
                tx_data_d  = msg_byte;
                cnt_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    if (idx_q == IDX_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_SEND;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            val_q    <= 8'h00;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            tx_valid <= tx_valid_d;
            tx_data  <= tx_data_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule
